count_seq_checker: RTL and testbench

- Downstream consumer of the free-running W-bit up-counter; samples its count output every qualified cycle.
- Checks that each valid sample is the previous valid sample +1, modulo 2^W.
- Reports wrap events, upstream restarts (an unexpected return to 0) and sequence errors.
- Sits between the counter and the status/debug logic. Errors are sticky until software clears them.

---
 rtl/count_seq_checker.sv | 159 +++++++++++++++
 tb/tb_count_seq_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// count_seq_checker: monitors a free-running W-bit up-counter and checks that
// each valid sample is the previous one plus one (mod 2^W). Reports wraps,
// upstream restarts and sequence errors. The error flag is sticky until clr.
// Optional build macro CNT_CHK_PERIOD_EN adds a 16-bit 'period' output that
// holds the number of cycles between the last two wrap pulses.
//
// state | meaning
// IDLE  | no reference yet; the next valid sample sets the expected value
// TRACK | locked; every valid sample is compared against exp
// ERR   | sequence broken; the next valid sample resynchronises
module count_seq_checker #(
  parameter int W  = 3,
  parameter int WC = 8
) (
  input  logic          clk,
  input  logic          res,
  input  logic [W-1:0]  cnt_in,
  input  logic          cnt_vld,
  input  logic          clr,
  output logic          wrap_pulse,
  output logic          restart_pulse,
  output logic [WC-1:0] wrap_cnt,
  output logic [WC-1:0] restart_cnt,
  output logic          err,
  output logic [W-1:0]  err_val,
  output logic          locked
`ifdef CNT_CHK_PERIOD_EN
  ,
  output logic [15:0]   period
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [W-1:0]  ONE_W  = W'(1);
  localparam logic [W-1:0]  ZERO_W = '0;
  localparam logic [WC-1:0] ONE_C  = WC'(1);
  localparam logic [WC-1:0] MAX_C  = '1;

  state_t       state, state_nxt;
  logic [W-1:0] exp_q, exp_nxt;
  logic         wrap_ev, restart_ev, err_ev;

  // State and expected-value registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
      exp_q <= '0;
    end else begin
      state <= state_nxt;
      exp_q <= exp_nxt;
    end
  end

  // Next state, next expected value and event decode for the current sample
  always_comb begin
    state_nxt  = state;
    exp_nxt    = exp_q;
    wrap_ev    = 1'b0;
    restart_ev = 1'b0;
    err_ev     = 1'b0;
    if (cnt_vld) begin
      case (state)
        IDLE, ERR: begin
          exp_nxt   = cnt_in + ONE_W;
          state_nxt = TRACK;
        end
        TRACK: begin
          if (cnt_in == exp_q) begin
            exp_nxt = exp_q + ONE_W;
            wrap_ev = (cnt_in == ZERO_W);
          end else if (cnt_in == ZERO_W) begin
            // A 0 that was not expected means the upstream counter restarted
            restart_ev = 1'b1;
            exp_nxt    = ONE_W;
          end else begin
            err_ev    = 1'b1;
            state_nxt = ERR;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign locked = (state == TRACK);

  // Registered event pulses; they fire even when clr is active
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wrap_pulse    <= 1'b0;
      restart_pulse <= 1'b0;
    end else begin
      wrap_pulse    <= wrap_ev;
      restart_pulse <= restart_ev;
    end
  end

  // Saturating event counters; an event coinciding with clr leaves a count of 1
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wrap_cnt    <= '0;
      restart_cnt <= '0;
    end else if (clr) begin
      wrap_cnt    <= WC'(wrap_ev);
      restart_cnt <= WC'(restart_ev);
    end else begin
      if (wrap_ev && (wrap_cnt != MAX_C))
        wrap_cnt <= wrap_cnt + ONE_C;
      if (restart_ev && (restart_cnt != MAX_C))
        restart_cnt <= restart_cnt + ONE_C;
    end
  end

  // Sticky error flag; err_val keeps the first offending sample since clr
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      err     <= 1'b0;
      err_val <= '0;
    end else if (clr) begin
      err     <= 1'b0;
      err_val <= '0;
    end else if (err_ev) begin
      err <= 1'b1;
      if (!err)
        err_val <= cnt_in;
    end
  end

`ifdef CNT_CHK_PERIOD_EN
  logic [15:0] cyc;
  logic        seen_wrap;

  // Cycles since the last wrap (or restart); period latches on every wrap after the first
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cyc       <= '0;
      seen_wrap <= 1'b0;
      period    <= '0;
    end else begin
      if (wrap_ev || restart_ev)
        cyc <= '0;
      else if (cyc != 16'hFFFF)
        cyc <= cyc + 16'd1;
      if (wrap_ev)
        seen_wrap <= 1'b1;
      if (clr)
        period <= '0;
      else if (wrap_ev && seen_wrap)
        period <= (cyc == 16'hFFFF) ? 16'hFFFF : cyc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Testbench for count_seq_checker: directed scenarios followed by randomized
// traffic, all checked every cycle against a behavioural reference model.
module tb_count_seq_checker;

  localparam int W    = 3;
  localparam int WC   = 2;
  localparam int M    = 1 << W;
  localparam int CMAX = (1 << WC) - 1;

  logic          clk = 1'b0;
  logic          res;
  logic [W-1:0]  cnt_in;
  logic          cnt_vld;
  logic          clr;
  logic          wrap_pulse, restart_pulse, err, locked;
  logic [WC-1:0] wrap_cnt, restart_cnt;
  logic [W-1:0]  err_val;
`ifdef CNT_CHK_PERIOD_EN
  logic [15:0]   period;
`endif

  count_seq_checker #(.W(W), .WC(WC)) dut (
    .clk           (clk),
    .res           (res),
    .cnt_in        (cnt_in),
    .cnt_vld       (cnt_vld),
    .clr           (clr),
    .wrap_pulse    (wrap_pulse),
    .restart_pulse (restart_pulse),
    .wrap_cnt      (wrap_cnt),
    .restart_cnt   (restart_cnt),
    .err           (err),
    .err_val       (err_val),
    .locked        (locked)
`ifdef CNT_CHK_PERIOD_EN
    ,
    .period        (period)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: "have_ref" means an expected value is known; "broken"
  // means the last comparison failed and the next sample is taken as truth.
  bit m_have_ref, m_broken;
  int m_next;
  bit m_wp, m_rp, m_err;
  int m_wc, m_rc, m_errval;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_have_ref = 0; m_broken = 0; m_next = 0;
    m_wp = 0; m_rp = 0; m_err = 0;
    m_wc = 0; m_rc = 0; m_errval = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    bit bad;
    bad  = 0;
    m_wp = 0;
    m_rp = 0;
    if (v) begin
      if (!m_have_ref || m_broken) begin
        m_next     = (d + 1) % M;
        m_have_ref = 1;
        m_broken   = 0;
      end else if (d == m_next) begin
        m_wp   = (d == 0);
        m_next = (d + 1) % M;
      end else if (d == 0) begin
        m_rp   = 1;
        m_next = 1 % M;
      end else begin
        bad      = 1;
        m_broken = 1;
      end
    end
    if (c) begin
      m_err    = 0;
      m_errval = 0;
      m_wc     = m_wp;
      m_rc     = m_rp;
    end else begin
      if (bad && !m_err) m_errval = d;
      if (bad) m_err = 1;
      if (m_wp && m_wc < CMAX) m_wc++;
      if (m_rp && m_rc < CMAX) m_rc++;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".wrap_pulse"},    int'(wrap_pulse),    int'(m_wp));
    chk({ctx, ".restart_pulse"}, int'(restart_pulse), int'(m_rp));
    chk({ctx, ".wrap_cnt"},      int'(wrap_cnt),      m_wc);
    chk({ctx, ".restart_cnt"},   int'(restart_cnt),   m_rc);
    chk({ctx, ".err"},           int'(err),           int'(m_err));
    chk({ctx, ".err_val"},       int'(err_val),       m_errval);
    chk({ctx, ".locked"},        int'(locked),        int'(m_have_ref && !m_broken));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare after it
  task automatic step(input string ctx, input bit v, input int d, input bit c);
    int dm;
    dm      = d % M;
    cnt_vld = v;
    cnt_in  = W'(dm);
    clr     = c;
    @(posedge clk);
    model_step(v, dm, c);
    #1;
    check_all(ctx);
  endtask

  initial begin
    int sent;
    res = 1'b0; cnt_in = '0; cnt_vld = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    res = 1'b1;

    // Counting 0..7,0..7,0 continuously: wraps on each return to 0
    for (int i = 0; i < 17; i++) step("count", 1, i % M, 0);
`ifdef CNT_CHK_PERIOD_EN
    chk("period", int'(period), 8);
`endif
    step("count", 1, 1, 0);

    // Restart: bring exp to 5 then send a valid 0
    for (int i = 2; i < 5; i++) step("pre_rst", 1, i, 0);
    step("restart", 1, 0, 0);
    step("after_rst", 1, 1, 0);
    step("after_rst", 1, 2, 0);

    // Error at exp=3: 6 breaks, 7 resyncs, 0 wraps, err stays
    step("err", 1, 6, 0);
    step("resync", 1, 7, 0);
    step("wrap_in_err", 1, 0, 0);
    step("follow", 1, 1, 0);
    step("clr", 0, 0, 1);
    step("post_clr", 1, 2, 0);

    // Gap in the valid stream with garbage on cnt_in
    for (int i = 0; i < 4; i++) step("gap", 0, $urandom_range(M - 1), 0);
    step("gap_end", 1, 3, 0);

    // Second error while err is already set must not overwrite err_val
    step("err_a", 1, 6, 0);
    step("resync_a", 1, 1, 0);
    step("err_b", 1, 5, 0);
    step("resync_b", 1, 6, 0);

    // Clear coinciding with a wrap: counter restarts at 1, pulse still fires
    step("pre_clrwrap", 1, 7, 0);
    step("clr_wrap", 1, 0, 1);

    // Saturation of the wrap counter over several wraps
    for (int i = 1; i < 5 * M + 3; i++) step("sat", 1, i % M, 0);

    // Asynchronous reset mid-cycle
    cnt_vld = 1'b0;
    #2;
    res = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    res = 1'b1;
    step("relock", 1, 4, 0);
    step("relock_next", 1, 5, 0);
    step("relock_next", 1, 6, 0);

    // Randomized traffic: mostly in sequence, with restarts, jumps, gaps, clears
    sent = 6;
    for (int i = 0; i < 1500; i++) begin
      int p, d;
      bit v, c;
      p = $urandom_range(99);
      v = ($urandom_range(99) < 80);
      c = ($urandom_range(99) < 5);
      if (p < 75)      d = (sent + 1) % M;
      else if (p < 87) d = 0;
      else             d = $urandom_range(M - 1);
      if (v) sent = d;
      step("rand", v, d, c);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
